// File: rtl/arbiter_types_pkg.sv
// Shared types for the L1-to-adaptor cache arbiter.
package arbiter_types_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  typedef enum logic {REQ_ICACHE, REQ_DCACHE} arb_req_t;
  typedef enum logic {OP_READ, OP_WRITE} arb_op_t;

endpackage

// File: rtl/rr_picker2.sv
// Two-way round-robin picker: a lone requester always wins; on a tie the
// requester that was not granted last time wins. Bit 0 is the I-cache,
// bit 1 is the D-cache.
module rr_picker2 import arbiter_types_pkg::*; (
  input  logic [1:0] req,
  input  arb_req_t   last,
  output logic       grant_valid,
  output arb_req_t   grant
);

  // Pick the winner from the current request vector and the last owner.
  always_comb begin
    grant_valid = |req;
    grant       = REQ_ICACHE;
    if (req[0] && req[1]) begin
      grant = (last == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
    end else if (req[1]) begin
      grant = REQ_DCACHE;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one cacheline adaptor port between the I-cache and the D-cache.
// One line transaction at a time: IDLE picks and latches a request, BUSY
// drives the adaptor until mem_resp, RESP pulses the owner's resp.
// Handshake: a cache raises read/write and holds it with stable addr/data
// until its resp pulse, then drops it in the following cycle; the adaptor
// sees mem_read/mem_write held until mem_resp, and both are dropped in the
// same cycle mem_resp arrives.
module cache_arbiter import arbiter_types_pkg::*; #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_q, state_d;
  arb_req_t          last_q, last_d;
  arb_req_t          owner_q, owner_d;
  arb_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

  logic     grant_valid;
  arb_req_t grant;

  rr_picker2 u_picker (
    .req         ({d_read | d_write, i_read}),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Next-state logic: arbitration and latching in IDLE, capture in BUSY.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          owner_d = grant;
          last_d  = grant;
          state_d = ARB_BUSY;
          if (grant == REQ_ICACHE) begin
            op_d    = OP_READ;
            addr_d  = i_addr;
            wdata_d = '0;
          end else begin
            // A simultaneous d_read and d_write is treated as a write.
            op_d    = d_write ? OP_WRITE : OP_READ;
            addr_d  = d_addr;
            wdata_d = d_write ? d_wdata : '0;
          end
        end
      end
      ARB_BUSY: begin
        if (mem_resp) begin
          state_d = ARB_RESP;
          if (op_q == OP_READ) begin
            if (owner_q == REQ_ICACHE) i_rdata_d = mem_rdata;
            else                       d_rdata_d = mem_rdata;
          end
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // State and latch registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ARB_IDLE;
      last_q    <= REQ_DCACHE;
      owner_q   <= REQ_ICACHE;
      op_q      <= OP_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Adaptor requests drop combinationally on mem_resp; resp pulses in RESP only.
  always_comb begin
    mem_read  = (state_q == ARB_BUSY) && (op_q == OP_READ)  && !mem_resp;
    mem_write = (state_q == ARB_BUSY) && (op_q == OP_WRITE) && !mem_resp;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_resp    = (state_q == ARB_RESP) && (owner_q == REQ_ICACHE);
    d_resp    = (state_q == ARB_RESP) && (owner_q == REQ_DCACHE);
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: behavioural adaptor, queue-driven
// cache requesters and a scoreboard of expected transactions in grant order.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;
  localparam int EW = 2 + AW + LW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset_n   = 1'b0;
  logic          i_read    = 1'b0;
  logic [AW-1:0] i_addr    = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read    = 1'b0;
  logic          d_write   = 1'b0;
  logic [AW-1:0] d_addr    = '0;
  logic [LW-1:0] d_wdata   = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_resp  = 1'b0;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // exp_q entry: {is_dcache, is_write, addr, wdata}; ordered by expected grant
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] ireq_q[$];
  logic [EW-1:0] dreq_q[$];   // {rd, wr, addr, wdata}

  int            rst_cycles  = 2;
  int            lat         = 4;
  int            cnt         = 0;
  int            resp_cyc    = 0;
  int            done_cnt    = 0;
  bit            scramble    = 1'b0;
  bit            prev_active = 1'b0;
  bit            prev_resp   = 1'b0;
  logic [LW-1:0] shadow_i    = '0;
  logic [LW-1:0] shadow_d    = '0;

  task automatic check_eq(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Line the behavioural adaptor returns for a given address.
  function automatic logic [LW-1:0] line_fn(input logic [AW-1:0] a);
    if (a == 32'h0000_1000) return {32{8'hA5}};
    return {8{a ^ 32'hC3C3_0000}};
  endfunction

  function automatic logic [EW-1:0] pack(input logic b1, input logic b0,
                                         input logic [AW-1:0] a, input logic [LW-1:0] w);
    return {b1, b0, a, w};
  endfunction

  // ---------------- monitor ----------------
  task automatic monitor();
    logic          act;
    logic [EW-1:0] cur;
    act = mem_read | mem_write;
    if (act && !prev_active) begin
      check_eq("txn_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        cur = exp_q[0];
        check_eq("mem_op", {mem_write, mem_read}, cur[EW-2] ? 2'b10 : 2'b01);
        check_eq("mem_addr", mem_addr, cur[EW-3 -: AW]);
        check_eq("mem_wdata", mem_wdata, cur[LW-1:0]);
      end
    end else if (act && exp_q.size() > 0) begin
      cur = exp_q[0];
      check_eq("mem_addr_hold", mem_addr, cur[EW-3 -: AW]);
      check_eq("mem_wdata_hold", mem_wdata, cur[LW-1:0]);
    end
    prev_active = act;
    if (i_resp || d_resp) begin
      check_eq("resp_pulse", prev_resp, 1'b0);
      check_eq("resp_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        check_eq("resp_owner", {d_resp, i_resp}, cur[EW-1] ? 2'b10 : 2'b01);
        check_eq("resp_latency", cyc, resp_cyc + 1);
        if (!cur[EW-2]) begin
          if (cur[EW-1]) shadow_d = line_fn(cur[EW-3 -: AW]);
          else           shadow_i = line_fn(cur[EW-3 -: AW]);
        end
        done_cnt++;
      end
      check_eq("i_rdata", i_rdata, shadow_i);
      check_eq("d_rdata", d_rdata, shadow_d);
    end
    prev_resp = i_resp | d_resp;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_adaptor();
    if (mem_resp) begin
      mem_resp = 1'b0;
      cnt      = 0;
    end else if (mem_read || mem_write) begin
      cnt++;
      if (cnt >= lat) begin
        mem_resp  = 1'b1;
        mem_rdata = line_fn(mem_addr);
        resp_cyc  = cyc;
      end
    end
  endtask

  task automatic drive_caches();
    logic [EW-1:0] e;
    if (i_resp) begin
      i_read = 1'b0;
      if (ireq_q.size() > 0) void'(ireq_q.pop_front());
    end else if (!i_read && ireq_q.size() > 0) begin
      i_read = 1'b1;
      i_addr = ireq_q[0];
    end
    if (d_resp) begin
      d_read  = 1'b0;
      d_write = 1'b0;
      if (dreq_q.size() > 0) void'(dreq_q.pop_front());
    end else if (!d_read && !d_write && dreq_q.size() > 0) begin
      e       = dreq_q[0];
      d_read  = e[EW-1];
      d_write = e[EW-2];
      d_addr  = e[EW-3 -: AW];
      d_wdata = e[LW-1:0];
    end else if (scramble && (d_read || d_write) && (mem_read || mem_write)) begin
      d_addr  = $urandom;
      d_wdata = {8{$urandom}};
    end
  endtask

  // Single process owns every DUT input: check first, then drive.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) monitor();
      if (rst_cycles > 0) begin
        rst_cycles--;
        reset_n     = 1'b0;
        i_read      = 1'b0;
        d_read      = 1'b0;
        d_write     = 1'b0;
        mem_resp    = 1'b0;
        cnt         = 0;
        prev_active = 1'b0;
        prev_resp   = 1'b0;
        shadow_i    = '0;
        shadow_d    = '0;
        exp_q.delete();
        ireq_q.delete();
        dreq_q.delete();
      end else begin
        reset_n = 1'b1;
        drive_adaptor();
        drive_caches();
      end
    end
  end

  task automatic do_reset(input int n);
    int guard = 0;
    rst_cycles = n;
    do begin
      @(negedge clk); #1;
      guard++;
    end while (!reset_n && guard < 50);
    check_eq("reset_release", reset_n, 1'b1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("txn_count", done_cnt, target);
    check_eq("exp_drained", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_i_resp"}, i_resp, 1'b0);
    check_eq({tag, "_d_resp"}, d_resp, 1'b0);
    check_eq({tag, "_mem_read"}, mem_read, 1'b0);
    check_eq({tag, "_mem_write"}, mem_write, 1'b0);
    check_eq({tag, "_mem_addr"}, mem_addr, '0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, '0);
    check_eq({tag, "_i_rdata"}, i_rdata, '0);
    check_eq({tag, "_d_rdata"}, d_rdata, '0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int            base;
    int            guard;
    logic [LW-1:0] w;

    do_reset(2);
    check_idle_outputs("rst");

    // Both caches request straight out of reset: I first, then D.
    lat  = 3;
    base = done_cnt;
    exp_q.push_back(pack(1'b0, 1'b0, 32'h0000_0800, '0));
    exp_q.push_back(pack(1'b1, 1'b0, 32'h0000_0900, '0));
    ireq_q.push_back(32'h0000_0800);
    dreq_q.push_back(pack(1'b1, 1'b0, 32'h0000_0900, {8{32'hDEAD_BEEF}}));
    wait_done(base + 2, 60);

    // Lone I-cache read with explicit request-to-mem_read latency.
    lat  = 4;
    base = done_cnt;
    exp_q.push_back(pack(1'b0, 1'b0, 32'h0000_1000, '0));
    ireq_q.push_back(32'h0000_1000);
    @(negedge clk); #1;
    check_eq("mem_read_t0", mem_read, 1'b0);
    @(negedge clk); #1;
    check_eq("mem_read_t1", mem_read, 1'b1);
    wait_done(base + 1, 40);
    check_eq("i_rdata_a5", i_rdata, {32{8'hA5}});

    // D-cache write with d_read also high: write wins, i_rdata untouched.
    base = done_cnt;
    exp_q.push_back(pack(1'b1, 1'b1, 32'h0000_2040, {32{8'h55}}));
    dreq_q.push_back(pack(1'b1, 1'b1, 32'h0000_2040, {32{8'h55}}));
    wait_done(base + 1, 40);
    check_eq("i_rdata_kept", i_rdata, {32{8'hA5}});

    // D-cache inputs wander while BUSY; latched copy must stay on the port.
    lat      = 6;
    scramble = 1'b1;
    base     = done_cnt;
    w        = {8{$urandom}};
    exp_q.push_back(pack(1'b1, 1'b1, 32'h0000_4080, w));
    dreq_q.push_back(pack(1'b0, 1'b1, 32'h0000_4080, w));
    wait_done(base + 1, 40);
    scramble = 1'b0;

    // Continuous demand from both: grants alternate I,D,I,D.
    lat  = $urandom_range(1, 5);
    base = done_cnt;
    w    = {8{$urandom}};
    exp_q.push_back(pack(1'b0, 1'b0, 32'h0000_5000, '0));
    exp_q.push_back(pack(1'b1, 1'b0, 32'h0000_6000, '0));
    exp_q.push_back(pack(1'b0, 1'b0, 32'h0000_5100, '0));
    exp_q.push_back(pack(1'b1, 1'b1, 32'h0000_6040, w));
    ireq_q.push_back(32'h0000_5000);
    ireq_q.push_back(32'h0000_5100);
    dreq_q.push_back(pack(1'b1, 1'b0, 32'h0000_6000, '0));
    dreq_q.push_back(pack(1'b0, 1'b1, 32'h0000_6040, w));
    wait_done(base + 4, 120);

    // Reset while BUSY: no resp, adaptor request dropped, state cleared.
    lat = 20;
    exp_q.push_back(pack(1'b0, 1'b0, 32'h0000_3000, '0));
    ireq_q.push_back(32'h0000_3000);
    guard = 0;
    while (!mem_read && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    check_eq("busy_before_reset", mem_read, 1'b1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    base = done_cnt;
    do_reset(1);
    check_idle_outputs("midrst");
    repeat (3) begin
      @(negedge clk); #1;
    end
    check_eq("no_resp_after_reset", done_cnt, base);

    // Normal I-cache read after the aborted transaction.
    lat = 4;
    exp_q.push_back(pack(1'b0, 1'b0, 32'h0000_1000, '0));
    ireq_q.push_back(32'h0000_1000);
    wait_done(base + 1, 40);
    check_eq("post_reset_rdata", i_rdata, {32{8'hA5}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
